// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_pkg
//  Purpose  : Shared definitions for the SNN core: default network sizes used
//             by the controller, the output layer and the output spike store,
//             plus the output-store state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package snn_pkg;

  // Default sizing shared across the SNN blocks.
  localparam int SNN_NUM_OUTPUTS = 10;
  localparam int SNN_CNT_WIDTH   = 16;
  localparam int SNN_ADDR_WIDTH  = 4;

  // Output spike store states.
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,  // counting spikes while the network runs
    ST_STORE = 2'd1,  // sweeping counts into result memory
    ST_DONE  = 2'd2   // sweep finished, winner valid
  } store_state_t;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/snn_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : snn_sat_counter
//  Purpose  : WIDTH-bit up counter that sticks at all-ones instead of wrapping.
//  Ports    : clk   - system clock, rising edge
//             rst   - asynchronous active-low reset
//             clr   - synchronous clear, dominates inc
//             inc   - increment request
//             count - current count
//  Revision : 1.0  initial release
// ============================================================================
module snn_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : snn_sat_counter
`default_nettype wire

// File: rtl/snn_output_spike_store.sv
`default_nettype none
// ============================================================================
//  Module   : snn_output_spike_store
//  Purpose  : Counts output-layer spikes per neuron while the network runs,
//             then, on controller request, sweeps the counts into the result
//             memory (one write per enabled cycle, ascending addresses) while
//             tracking the max-count neuron. outputs_done flags completion.
//  Ports    : clk, rst (async active-low)
//             counts_clr      - clear counters/winner, back to accumulate
//             spike_valid     - spikes_in valid this cycle
//             spikes_in       - spike vector, bit i = neuron i
//             output_cntr_rst - restart sweep at index 0
//             output_cntr_en  - advance sweep by one write
//             mem_wr_en/mem_addr/mem_wr_data - result memory write port
//             winner_idx/winner_cnt          - argmax result
//             outputs_done                   - sweep complete (level)
//  Revision : 1.0  initial release
// ============================================================================
module snn_output_spike_store
  import snn_pkg::*;
#(
  parameter int NUM_OUTPUTS = SNN_NUM_OUTPUTS,
  parameter int CNT_WIDTH   = SNN_CNT_WIDTH,
  parameter int ADDR_WIDTH  = SNN_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   counts_clr,
  input  logic                   spike_valid,
  input  logic [NUM_OUTPUTS-1:0] spikes_in,
  input  logic                   output_cntr_rst,
  input  logic                   output_cntr_en,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [CNT_WIDTH-1:0]   mem_wr_data,
  output logic [ADDR_WIDTH-1:0]  winner_idx,
  output logic [CNT_WIDTH-1:0]   winner_cnt,
  output logic                   outputs_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OUTPUTS - 1);

  store_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
  logic                    mem_wr_en_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [CNT_WIDTH-1:0]    mem_wr_data_nxt;
  logic [ADDR_WIDTH-1:0]   winner_idx_nxt;
  logic [CNT_WIDTH-1:0]    winner_cnt_nxt;
  logic                    outputs_done_nxt;

  logic [CNT_WIDTH-1:0]    cnt [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]  spike_inc;
  logic [CNT_WIDTH-1:0]    sel_cnt;

  // Counters only move while accumulating; counts_clr wins inside the counter.
  assign spike_inc = spikes_in & {NUM_OUTPUTS{spike_valid && (state == ST_ACCUM)}};

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
    snn_sat_counter #(
      .WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (counts_clr),
      .inc   (spike_inc[i]),
      .count (cnt[i])
    );
  end

  // Explicit compare mux keeps the read in range for non-power-of-two sizes.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (idx == ADDR_WIDTH'(i)) begin
        sel_cnt = cnt[i];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    mem_wr_en_nxt    = 1'b0;
    mem_addr_nxt     = mem_addr;
    mem_wr_data_nxt  = mem_wr_data;
    winner_idx_nxt   = winner_idx;
    winner_cnt_nxt   = winner_cnt;
    outputs_done_nxt = outputs_done;

    if (counts_clr) begin
      state_nxt        = ST_ACCUM;
      idx_nxt          = '0;
      winner_idx_nxt   = '0;
      winner_cnt_nxt   = '0;
      outputs_done_nxt = 1'b0;
    end else if (output_cntr_rst) begin
      // Restart takes precedence over a simultaneous enable: no write.
      state_nxt        = ST_STORE;
      idx_nxt          = '0;
      winner_idx_nxt   = '0;
      winner_cnt_nxt   = '0;
      outputs_done_nxt = 1'b0;
    end else begin
      case (state)
        ST_STORE: begin
          if (output_cntr_en) begin
            mem_wr_en_nxt   = 1'b1;
            mem_addr_nxt    = idx;
            mem_wr_data_nxt = sel_cnt;
            // Strict compare: earlier (lower) index keeps ties.
            if (sel_cnt > winner_cnt) begin
              winner_idx_nxt = idx;
              winner_cnt_nxt = sel_cnt;
            end
            if (idx == LAST_IDX) begin
              state_nxt        = ST_DONE;
              outputs_done_nxt = 1'b1;
            end else begin
              idx_nxt = idx + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          outputs_done_nxt = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_ACCUM;
      idx          <= '0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      winner_idx   <= '0;
      winner_cnt   <= '0;
      outputs_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      mem_wr_en    <= mem_wr_en_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wr_data  <= mem_wr_data_nxt;
      winner_idx   <= winner_idx_nxt;
      winner_cnt   <= winner_cnt_nxt;
      outputs_done <= outputs_done_nxt;
    end
  end

endmodule : snn_output_spike_store
`default_nettype wire

// File: tb/tb_snn_output_spike_store.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_output_spike_store
//  Purpose  : Self-checking bench for snn_output_spike_store (10 outputs,
//             4-bit counters so saturation is reachable quickly).
//  Revision : 1.0  initial release
// ============================================================================
module tb_snn_output_spike_store;

  localparam int N    = 10;
  localparam int CW   = 4;
  localparam int AW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          counts_clr = 1'b0;
  logic          spike_valid = 1'b0;
  logic [N-1:0]  spikes_in = '0;
  logic          output_cntr_rst = 1'b0;
  logic          output_cntr_en = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wr_data;
  logic [AW-1:0] winner_idx;
  logic [CW-1:0] winner_cnt;
  logic          outputs_done;

  int model [N];
  int errors = 0;
  int checks = 0;

  snn_output_spike_store #(
    .NUM_OUTPUTS (N),
    .CNT_WIDTH   (CW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .counts_clr      (counts_clr),
    .spike_valid     (spike_valid),
    .spikes_in       (spikes_in),
    .output_cntr_rst (output_cntr_rst),
    .output_cntr_en  (output_cntr_en),
    .mem_wr_en       (mem_wr_en),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .winner_idx      (winner_idx),
    .winner_cnt      (winner_cnt),
    .outputs_done    (outputs_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) model[i] = 0;
  endtask

  // One timestep while accumulating.
  task automatic accum(input logic [N-1:0] s, input logic v);
    spike_valid = v;
    spikes_in   = s;
    tick();
    spike_valid = 1'b0;
    spikes_in   = '0;
    if (v) begin
      for (int i = 0; i < N; i++)
        if (s[i] && model[i] < CMAX) model[i]++;
    end
  endtask

  task automatic clear();
    counts_clr = 1'b1;
    tick();
    counts_clr = 1'b0;
    model_zero();
  endtask

  function automatic int exp_winner();
    int best = 0;
    for (int i = 1; i < N; i++)
      if (model[i] > model[best]) best = i;
    return best;
  endfunction

  // Full sweep. pause_at/abort_at < 0 disables; noisy pulses spikes during STORE.
  task automatic sweep(input int pause_at, input int pause_len, input int abort_at,
                       input bit with_en, input bit noisy);
    int w;
    output_cntr_rst = 1'b1;
    output_cntr_en  = with_en;
    tick();
    output_cntr_rst = 1'b0;
    chk("restart_wr_en", mem_wr_en, 0);
    chk("restart_done", outputs_done, 0);
    chk("restart_win_idx", winner_idx, 0);
    chk("restart_win_cnt", winner_cnt, 0);
    for (int k = 0; k < N; k++) begin
      if (k == abort_at) begin
        output_cntr_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_data", mem_wr_data, 0);
        chk("abort_win_idx", winner_idx, 0);
        chk("abort_win_cnt", winner_cnt, 0);
        chk("abort_done", outputs_done, 0);
        tick();
        chk("abort_hold_wr_en", mem_wr_en, 0);
        rst = 1'b1;
        model_zero();
        return;
      end
      if (k == pause_at) begin
        output_cntr_en = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          if (noisy) begin
            spike_valid = 1'b1;
            spikes_in   = N'($urandom_range(1, (1 << N) - 1));
          end
          tick();
          chk("pause_wr_en", mem_wr_en, 0);
        end
        spike_valid = 1'b0;
      end
      output_cntr_en = 1'b1;
      if (noisy) begin
        spike_valid = 1'b1;
        spikes_in   = N'($urandom);
      end
      tick();
      spike_valid = 1'b0;
      spikes_in   = '0;
      chk("sweep_wr_en", mem_wr_en, 1);
      chk("sweep_addr", mem_addr, k);
      chk("sweep_data", mem_wr_data, model[k]);
      chk("sweep_done", outputs_done, (k == N - 1) ? 1 : 0);
    end
    // Enable stays high in DONE and must be ignored.
    tick();
    w = exp_winner();
    chk("done_wr_en", mem_wr_en, 0);
    chk("done_level", outputs_done, 1);
    chk("done_win_idx", winner_idx, w);
    chk("done_win_cnt", winner_cnt, model[w]);
    output_cntr_en = 1'b0;
  endtask

  initial begin
    model_zero();

    // Reset state.
    tick();
    tick();
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wr_data, 0);
    chk("rst_win_idx", winner_idx, 0);
    chk("rst_win_cnt", winner_cnt, 0);
    chk("rst_done", outputs_done, 0);
    rst = 1'b1;
    tick();

    // Accumulate then store: neurons 0 and 2 tie at 3.
    for (int c = 0; c < 3; c++) accum(10'b0000000101, 1'b1);
    sweep(-1, 0, -1, 1'b0, 1'b0);
    chk("t1_win_idx", winner_idx, 0);
    chk("t1_win_cnt", winner_cnt, 3);

    // Saturation on bit 2.
    clear();
    for (int c = 0; c < 20; c++) accum(10'b0000000100, 1'b1);
    sweep(-1, 0, -1, 1'b0, 1'b0);
    chk("sat_win_idx", winner_idx, 2);
    chk("sat_win_cnt", winner_cnt, 15);

    // Random accumulation, pause at idx 4, spikes pulsed during STORE.
    clear();
    for (int c = 0; c < 30; c++)
      accum(N'($urandom), ($urandom_range(0, 3) != 0));
    sweep(4, 3, -1, 1'b0, 1'b1);

    // counts_clr beats a simultaneous spike_valid.
    clear();
    for (int c = 0; c < 5; c++) accum(N'($urandom), 1'b1);
    counts_clr  = 1'b1;
    spike_valid = 1'b1;
    spikes_in   = '1;
    tick();
    counts_clr  = 1'b0;
    spike_valid = 1'b0;
    spikes_in   = '0;
    model_zero();
    sweep(-1, 0, -1, 1'b0, 1'b0);

    // Restart with enable in DONE: restart only, sweep begins at 0.
    sweep(-1, 0, -1, 1'b1, 1'b0);

    // counts_clr beats output_cntr_rst: block stays accumulating.
    counts_clr      = 1'b1;
    output_cntr_rst = 1'b1;
    tick();
    counts_clr      = 1'b0;
    output_cntr_rst = 1'b0;
    model_zero();
    output_cntr_en  = 1'b1;
    tick();
    chk("clr_vs_rst_wr_en", mem_wr_en, 0);
    chk("clr_vs_rst_done", outputs_done, 0);
    output_cntr_en  = 1'b0;
    accum(10'b1000000000, 1'b1);
    accum(10'b1000000000, 1'b1);
    sweep(-1, 0, -1, 1'b0, 1'b0);

    // Async reset mid-sweep at idx 6, then a clean zero sweep.
    clear();
    for (int c = 0; c < 12; c++) accum(N'($urandom), 1'b1);
    sweep(-1, 0, 6, 1'b0, 1'b0);
    tick();
    sweep(-1, 0, -1, 1'b0, 1'b0);
    chk("post_rst_win_idx", winner_idx, 0);
    chk("post_rst_win_cnt", winner_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_snn_output_spike_store
`default_nettype wire

// File: doc/snn_output_spike_store.md
Name: snn_output_spike_store

Overview:
- Downstream stage of the SNN core controller.
- Accumulates per-output-neuron spike counts while the network runs. When the controller requests it, sweeps the counts into the output result memory and tracks the winning (max-count) neuron.
- Returns outputs_done so the controller can go back to idle.

Parameters:
- NUM_OUTPUTS, 10, number of output neurons (≥2)
- CNT_WIDTH, 16, width of each spike counter and of mem_wr_data
- ADDR_WIDTH, 4, result-memory address width (2^ADDR_WIDTH ≥ NUM_OUTPUTS)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- counts_clr  in  1  clear all counters/winner; driven by network_start
- spike_valid  in  1  timestep strobe; spikes_in is valid this cycle
- spikes_in  in  NUM_OUTPUTS  output-layer spike vector, bit i = neuron i
- output_cntr_rst  in  1  from controller: restart store sweep at index 0
- output_cntr_en  in  1  from controller: advance store sweep
- mem_wr_en  out  1  result-memory write strobe
- mem_addr  out  ADDR_WIDTH  result-memory write address
- mem_wr_data  out  CNT_WIDTH  spike count being written
- winner_idx  out  ADDR_WIDTH  index of max-count neuron (valid when outputs_done)
- winner_cnt  out  CNT_WIDTH  count of winner
- outputs_done  out  1  level, high when sweep complete

Behaviour:
- Reset (rst=0, async): state ACCUM; all counters 0; sweep index 0; every output 0.
- States: ACCUM, STORE, DONE. All outputs are registered.
- ACCUM:
  - Each cycle spike_valid=1, counter[i] increments for every set bit of spikes_in[i].
  - Counters saturate at 2^CNT_WIDTH-1; no wrap.
  - output_cntr_rst=1 → STORE: idx←0, winner_idx←0, winner_cnt←0.
- STORE:
  - Counters are frozen; spike_valid is ignored.
  - Each cycle output_cntr_en=1:
    - Register mem_wr_en=1, mem_addr=idx, mem_wr_data=counter[idx].
    - If counter[idx] > winner_cnt (strictly greater), update the winner. Ties resolve to the lowest index.
    - idx++.
  - The write for idx is visible on the ports one cycle after the enabling edge.
  - output_cntr_en=0 pauses the sweep: mem_wr_en=0, idx held.
  - The write of idx=NUM_OUTPUTS-1 moves the block to DONE. outputs_done rises on the same edge as that last mem_wr_en.
- DONE:
  - outputs_done=1, mem_wr_en=0.
  - winner_idx/winner_cnt hold.
  - output_cntr_en is ignored.
- Sweep length: exactly NUM_OUTPUTS writes, addresses 0..NUM_OUTPUTS-1 ascending, no gaps.
- counts_clr (any state): counters 0, winner 0, outputs_done 0, mem_wr_en 0, state ACCUM.
  - counts_clr beats a simultaneous spike_valid; that timestep is lost.
  - counts_clr beats a simultaneous output_cntr_rst.
- output_cntr_rst in STORE or DONE restarts the sweep from idx 0 with winner cleared and outputs_done=0. Counters are unchanged.
- output_cntr_rst together with output_cntr_en: restart only, no write that cycle.
- Async reset mid-sweep aborts immediately; no partial-state retention.

Decomposition:
- Shared package snn_pkg holds:
  - the store state enum (ACCUM/STORE/DONE)
  - default NUM_OUTPUTS / CNT_WIDTH constants shared with the controller and the output layer
- One sub-module: snn_sat_counter, a single CNT_WIDTH saturating counter with clr and inc. It is instantiated NUM_OUTPUTS times via generate.
- The sweep/argmax FSM stays in the top module.

Test Plan:
- Accumulate then store, NUM_OUTPUTS=10:
  - Stimulus: spikes_in=10'b0000000101 for 3 valid cycles, then output_cntr_rst, then output_cntr_en held high.
  - Required: 10 writes, addr 0..9, data 3,0,3,0,…; winner_idx=0 (tie → lowest), winner_cnt=3; outputs_done high with the last write.
- Saturation, CNT_WIDTH=4:
  - Stimulus: bit 2 spiking for 20 valid cycles.
  - Required: counter[2] reads 15, no wrap; winner_idx=2, winner_cnt=15.
- Pause and ignore:
  - Stimulus: output_cntr_en deasserted for 3 cycles mid-sweep at idx=4; spike_valid pulsed during STORE.
  - Required: no writes during the pause; resumes at addr 4; counts unchanged.
- Simultaneous events:
  - counts_clr together with spike_valid → all counters 0.
  - output_cntr_rst together with output_cntr_en in DONE → outputs_done=0, next write at addr 0.
- Async reset mid-sweep:
  - Stimulus: rst low at idx=6.
  - Required: all outputs 0 immediately; after release, state ACCUM with zero counts; a new sweep writes all zeros with winner_idx=0.
